// File: rtl/spi_cfg_pkg.sv
// Shared constants and types for the SPI coefficient loader: command bytes,
// FSM state encoding, coefficient indices and default coefficient format.
package spi_cfg_pkg;

   localparam int COEF_W_DEF    = 64;
   localparam int COEF_FRAC_DEF = 60;
   localparam int NCOEF_DEF     = 5;

   localparam logic [7:0] CMD_READ   = 8'h01;
   localparam logic [7:0] CMD_WRITE  = 8'h02;
   localparam logic [7:0] CMD_COMMIT = 8'h03;
   localparam logic [7:0] CMD_CLRERR = 8'h04;

   localparam logic [2:0] IDX_Y1 = 3'd0;
   localparam logic [2:0] IDX_Y2 = 3'd1;
   localparam logic [2:0] IDX_X0 = 3'd2;
   localparam logic [2:0] IDX_X1 = 3'd3;
   localparam logic [2:0] IDX_X2 = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DATA   = 3'd3,
      ST_IGNORE = 3'd4
   } fsm_state_e;

endpackage

// File: rtl/spi_coeff_loader_coef_bank.sv
// Shadow and live coefficient banks (HP entries 0..NCOEF-1, LP after them).
// Live only changes on the commit strobe, so filters always see a whole set.
module coef_bank
   import spi_cfg_pkg::*;
#(
   parameter int COEF_W    = COEF_W_DEF,
   parameter int COEF_FRAC = COEF_FRAC_DEF,
   parameter int NCOEF     = NCOEF_DEF
) (
   input  logic                           clk_48,
   input  logic                           reset,
   input  logic                           wr_en,
   input  logic [3:0]                     wr_addr,
   input  logic [COEF_W-1:0]              wr_data,
   input  logic                           commit,
   output logic [NCOEF-1:0][COEF_W-1:0]   hp_coeff,
   output logic [NCOEF-1:0][COEF_W-1:0]   lp_coeff
);

   localparam int NENT = 2 * NCOEF;

   logic [COEF_W-1:0] r_shadow [NENT];
   logic [COEF_W-1:0] r_live   [NENT];

   // x0 of each filter resets to 1.0 so the filters start as identity
   function automatic logic [COEF_W-1:0] reset_val(input int idx);
      if ((idx % NCOEF) == int'(IDX_X0)) begin
         return COEF_W'(1) << COEF_FRAC;
      end else begin
         return '0;
      end
   endfunction

   // Shadow bank: one entry written per completed 8-byte word
   always_ff @(posedge clk_48) begin
      if (reset) begin
         for (int i = 0; i < NENT; i++) begin
            r_shadow[i] <= reset_val(i);
         end
      end else if (wr_en && (wr_addr < 4'(NENT))) begin
         r_shadow[wr_addr] <= wr_data;
      end
   end

   // Live bank: whole-bank copy on commit; a same-edge shadow write is not seen
   always_ff @(posedge clk_48) begin
      if (reset) begin
         for (int i = 0; i < NENT; i++) begin
            r_live[i] <= reset_val(i);
         end
      end else if (commit) begin
         for (int i = 0; i < NENT; i++) begin
            r_live[i] <= r_shadow[i];
         end
      end
   end

   // Present live registers in filter index order
   always_comb begin
      for (int i = 0; i < NCOEF; i++) begin
         hp_coeff[i] = r_live[i];
         lp_coeff[i] = r_live[NCOEF + i];
      end
   end

endmodule

// File: rtl/spi_coeff_loader.sv
// SPI byte-stream decoder that loads biquad coefficients into a shadow bank
// and commits them to the live bank on the next sample boundary.
module spi_coeff_loader
   import spi_cfg_pkg::*;
#(
   parameter int COEF_W    = COEF_W_DEF,
   parameter int COEF_FRAC = COEF_FRAC_DEF,
   parameter int NCOEF     = NCOEF_DEF
) (
   input  logic                           clk_48,
   input  logic                           reset,
   input  logic                           cs_active,
   input  logic                           rx_valid,
   input  logic [7:0]                     rx_byte,
   input  logic                           sample_tick,
   output logic [NCOEF-1:0][COEF_W-1:0]   hp_coeff,
   output logic [NCOEF-1:0][COEF_W-1:0]   lp_coeff,
   output logic                           commit_done,
   output logic                           commit_pending,
   output logic                           err,
   output logic                           busy
);

   localparam int         NB        = COEF_W / 8;
   localparam int         CW        = $clog2(NB);
   localparam logic [3:0] L_NCOEF   = 4'(NCOEF);
   localparam logic [3:0] LAST_ADDR = 4'(2 * NCOEF - 1);

   fsm_state_e         r_state;
   logic [3:0]         r_addr;
   logic [CW-1:0]      r_cnt;
   logic [COEF_W-9:0]  r_asm;
   logic               r_ovr;
   logic               r_err;
   logic               r_pending;
   logic               r_done;
   logic               r_busy;

   fsm_state_e         w_state_nxt;
   logic [3:0]         w_addr_nxt;
   logic [CW-1:0]      w_cnt_nxt;
   logic [COEF_W-9:0]  w_asm_nxt;
   logic               w_ovr_nxt;
   logic               w_err_set;
   logic               w_err_clr;
   logic               w_pend_set;
   logic               w_wr_en;
   logic [COEF_W-1:0]  w_shift;
   logic               w_commit;

   assign w_shift  = {r_asm, rx_byte};
   assign w_commit = r_pending & sample_tick;

   // Frame decoder: next state, address/counter updates and event strobes
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_cnt_nxt   = r_cnt;
      w_asm_nxt   = r_asm;
      w_ovr_nxt   = r_ovr;
      w_err_set   = 1'b0;
      w_err_clr   = 1'b0;
      w_pend_set  = 1'b0;
      w_wr_en     = 1'b0;
      if (!cs_active) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_asm_nxt   = '0;
         w_ovr_nxt   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
               if (rx_valid) begin
                  w_state_nxt = ST_IGNORE;
                  case (rx_byte)
                     CMD_WRITE:  w_state_nxt = ST_ADDR;
                     CMD_COMMIT: w_pend_set  = 1'b1;
                     CMD_CLRERR: w_err_clr   = 1'b1;
                     CMD_READ:   w_err_set   = 1'b0;
                     default:    w_err_set   = 1'b1;
                  endcase
               end else begin
                  w_state_nxt = ST_CMD;
               end
            end
            ST_ADDR: begin
               if (rx_valid) begin
                  if ((rx_byte[7:5] != 3'b000) || rx_byte[3] || (rx_byte[2:0] > IDX_X2)) begin
                     w_err_set   = 1'b1;
                     w_state_nxt = ST_IGNORE;
                  end else begin
                     w_state_nxt = ST_DATA;
                     w_cnt_nxt   = '0;
                     w_asm_nxt   = '0;
                     w_addr_nxt  = rx_byte[4] ? (L_NCOEF + {1'b0, rx_byte[2:0]})
                                              : {1'b0, rx_byte[2:0]};
                  end
               end else begin
                  w_state_nxt = ST_ADDR;
               end
            end
            ST_DATA: begin
               if (rx_valid) begin
                  w_asm_nxt = w_shift[COEF_W-9:0];
                  if (r_cnt == CW'(NB - 1)) begin
                     w_wr_en   = 1'b1;
                     w_cnt_nxt = '0;
                     if (r_addr == LAST_ADDR) begin
                        w_state_nxt = ST_IGNORE;
                        w_ovr_nxt   = 1'b1;
                     end else begin
                        w_addr_nxt = r_addr + 4'd1;
                     end
                  end else begin
                     w_cnt_nxt = r_cnt + CW'(1);
                  end
               end else begin
                  w_state_nxt = ST_DATA;
               end
            end
            ST_IGNORE: begin
               // bytes after the final bank entry are an overrun
               if (rx_valid && r_ovr) begin
                  w_err_set = 1'b1;
               end else begin
                  w_err_set = 1'b0;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Control registers; err clear has priority over a same-cycle set
   always_ff @(posedge clk_48) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_addr    <= 4'd0;
         r_cnt     <= '0;
         r_asm     <= '0;
         r_ovr     <= 1'b0;
         r_err     <= 1'b0;
         r_pending <= 1'b0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_asm     <= w_asm_nxt;
         r_ovr     <= w_ovr_nxt;
         r_err     <= w_err_clr ? 1'b0 : (r_err | w_err_set);
         r_pending <= w_commit ? 1'b0 : (r_pending | w_pend_set);
         r_done    <= w_commit;
         r_busy    <= (w_state_nxt != ST_IDLE);
      end
   end

   coef_bank #(
      .COEF_W    (COEF_W),
      .COEF_FRAC (COEF_FRAC),
      .NCOEF     (NCOEF)
   ) u_bank (
      .clk_48   (clk_48),
      .reset    (reset),
      .wr_en    (w_wr_en),
      .wr_addr  (r_addr),
      .wr_data  (w_shift),
      .commit   (w_commit),
      .hp_coeff (hp_coeff),
      .lp_coeff (lp_coeff)
   );

   assign commit_done    = r_done;
   assign commit_pending = r_pending;
   assign err            = r_err;
   assign busy           = r_busy;

endmodule
